// File: rtl/y86_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | y86_regfile: Y86 architectural register file, dual write / dual read,    |
// | same-cycle bypass, wrapping write counter and sticky illegal-ID flag.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module y86_regfile #(
   parameter int DATA_W = 32,
   parameter int ID_W   = 8,
   parameter int NREG   = 8,
   parameter int BYPASS = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ID_W-1:0]   wb_dstE,
   input  logic [DATA_W-1:0] wb_valE,
   input  logic [ID_W-1:0]   wb_dstM,
   input  logic [DATA_W-1:0] wb_valM,
   input  logic [ID_W-1:0]   d_srcA,
   input  logic [ID_W-1:0]   d_srcB,
   output logic [DATA_W-1:0] d_rvalA,
   output logic [DATA_W-1:0] d_rvalB,
   output logic [15:0]       wr_cnt,
   output logic              id_err,
   input  logic              id_err_clr
);

   localparam int              IDX_W    = (NREG > 1) ? $clog2(NREG) : 1;
   localparam logic [ID_W-1:0] ID_NONE  = ID_W'(15);
   localparam logic [ID_W-1:0] ID_LIMIT = ID_W'(NREG);

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [15:0]       wr_cnt_q, wr_cnt_d;
   logic              id_err_q, id_err_d;

   logic e_legal, m_legal, a_legal, b_legal;
   logic e_bad, m_bad, a_bad, b_bad;
   logic we_e, we_m;
   logic [1:0] wr_inc;

   assign e_legal = (wb_dstE < ID_LIMIT);
   assign m_legal = (wb_dstM < ID_LIMIT);
   assign a_legal = (d_srcA < ID_LIMIT);
   assign b_legal = (d_srcB < ID_LIMIT);

   assign e_bad = !e_legal && (wb_dstE != ID_NONE);
   assign m_bad = !m_legal && (wb_dstM != ID_NONE);
   assign a_bad = !a_legal && (d_srcA != ID_NONE);
   assign b_bad = !b_legal && (d_srcB != ID_NONE);

   // M port owns the destination when both ports target the same register.
   assign we_m   = m_legal;
   assign we_e   = e_legal && !(m_legal && (wb_dstM == wb_dstE));
   assign wr_inc = {1'b0, we_e} + {1'b0, we_m};

   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (we_e) begin
         regs_d[wb_dstE[IDX_W-1:0]] = wb_valE;
      end
      if (we_m) begin
         regs_d[wb_dstM[IDX_W-1:0]] = wb_valM;
      end
      wr_cnt_d = wr_cnt_q + 16'(wr_inc);
      id_err_d = e_bad || m_bad || a_bad || b_bad || (id_err_q && !id_err_clr);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
         wr_cnt_q <= '0;
         id_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wr_cnt_q <= wr_cnt_d;
         id_err_q <= id_err_d;
      end
   end

   function automatic logic [DATA_W-1:0] read_port(input logic [ID_W-1:0] src,
                                                   input logic            legal);
      logic [DATA_W-1:0] r;
      r = '0;
      if (legal) begin
         r = regs_q[src[IDX_W-1:0]];
         if (BYPASS != 0) begin
            if (m_legal && (src == wb_dstM)) begin
               r = wb_valM;
            end else if (e_legal && (src == wb_dstE)) begin
               r = wb_valE;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      d_rvalA = read_port(d_srcA, a_legal);
      d_rvalB = read_port(d_srcB, b_legal);
   end

   assign wr_cnt = wr_cnt_q;
   assign id_err = id_err_q;

endmodule
`default_nettype wire
